// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// - fetch_state_e : FSM encodings (F_LO, F_HI, LOAD)
// - ADDR_W_DEF    : default halfword address width
// - HALF_W_DEF    : default memory word width
// - RESET_PC_DEF  : default restart address (even halfword address)
`ifndef INSTR_FETCH_SEQ_PKG_SV
`define INSTR_FETCH_SEQ_PKG_SV
package instr_fetch_seq_pkg;

    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned HALF_W_DEF   = 16;
    localparam int unsigned RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        F_LO = 2'd0,   // read low halfword at pc
        F_HI = 2'd1,   // read high halfword at pc+1, complete or stall
        LOAD = 2'd2    // fetch parked, memory writes accepted
    } fetch_state_e;

endpackage
`endif

// File: rtl/instr_fetch_seq_out_buf.sv
// fetch_out_buf: single-entry instruction buffer towards decode.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture in_instr/in_pc and mark valid
//   flush             drop the held entry (wins over load)
//   consume           consumer ready; with valid this is a handshake
//   in_instr, in_pc   entry to capture
//   out_valid, out_instr, out_pc  held entry
// Handshake: an entry transfers on a rising edge where out_valid & consume
// are both 1; out_valid never depends combinationally on consume, and the
// held instr/pc do not change while out_valid is 1 and no transfer occurs.
module fetch_out_buf #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic               consume,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            // A beat handshaken in the flush cycle is treated as consumed,
            // so clearing valid is correct either way.
            out_valid <= 1'b0;
        end else if (load) begin
            // Load may coincide with a consume: the new entry replaces it.
            out_valid <= 1'b1;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (out_valid && consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: fetch sequencer for a 16-bit-wide instruction memory.
// Owns the PC, reads two halfwords per 32-bit instruction and presents
// {hi,lo} to decode; supports branch redirect/flush and a program-load mode.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   mem_addr/mem_rdata              combinational memory read port
//   mem_we/mem_wdata                memory write port (LOAD state only)
//   prog_mode                       level: park fetch and accept loads
//   load_valid/load_ready/load_addr/load_data   program-load beats
//   redir_valid/redir_pc            single-cycle redirect (even target)
//   out_valid/out_ready/out_instr/out_pc        instruction to decode
//   fetch_err                       sticky: odd redirect target seen
//   dbg_state                       current FSM state
// Handshake: an instruction transfers on a rising edge with
// out_valid & out_ready; a load beat is written on any LOAD-state edge with
// load_valid (load_ready is simply 1 throughout LOAD).
module instr_fetch_seq
    import instr_fetch_seq_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned HALF_W   = HALF_W_DEF,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [HALF_W-1:0]   mem_rdata,
    output logic                mem_we,
    output logic [HALF_W-1:0]   mem_wdata,
    input  logic                prog_mode,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [HALF_W-1:0]   load_data,
    input  logic                redir_valid,
    input  logic [ADDR_W-1:0]   redir_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*HALF_W-1:0] out_instr,
    output logic [ADDR_W-1:0]   out_pc,
    output logic                fetch_err,
    output logic [1:0]          dbg_state
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    fetch_state_e        state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n;
    logic [HALF_W-1:0]   lo_q, lo_n;
    logic                err_n;
    logic                buf_load, buf_flush;
    logic                redir_ok;
    logic                hi_done;

    // State, PC and low-half register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= F_LO;
            pc        <= PC_RST;
            lo_q      <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            lo_q      <= lo_n;
            fetch_err <= err_n;
        end
    end

    // Next-state, PC update and memory-port muxing
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        lo_n       = lo_q;
        err_n      = fetch_err;
        mem_addr   = pc;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        load_ready = 1'b0;
        buf_load   = 1'b0;
        buf_flush  = 1'b0;
        // Odd targets would split an instruction across fetch pairs.
        redir_ok   = redir_valid && !redir_pc[0];
        // F_HI may only overwrite the buffer if it is empty or draining now.
        hi_done    = !out_valid || out_ready;

        case (state)
            F_LO: begin
                mem_addr = pc;
                if (prog_mode) begin
                    state_n   = LOAD;
                    buf_flush = 1'b1;
                end else if (redir_ok) begin
                    pc_n      = redir_pc;
                    buf_flush = 1'b1;
                    state_n   = F_LO;
                end else begin
                    if (redir_valid) begin
                        err_n = 1'b1;
                    end
                    lo_n    = mem_rdata;
                    state_n = F_HI;
                end
            end

            F_HI: begin
                mem_addr = pc + ADDR_W'(1);
                if (prog_mode) begin
                    state_n   = LOAD;
                    buf_flush = 1'b1;
                end else if (redir_ok) begin
                    pc_n      = redir_pc;
                    buf_flush = 1'b1;
                    state_n   = F_LO;
                end else begin
                    if (redir_valid) begin
                        err_n = 1'b1;
                    end
                    if (hi_done) begin
                        buf_load = 1'b1;
                        pc_n     = pc + ADDR_W'(2);
                        state_n  = F_LO;
                    end
                end
            end

            LOAD: begin
                load_ready = 1'b1;
                mem_addr   = load_addr;
                mem_wdata  = load_data;
                mem_we     = load_valid;
                if (!prog_mode) begin
                    pc_n    = PC_RST;
                    state_n = F_LO;
                end
            end

            default: begin
                state_n = F_LO;
            end
        endcase
    end

    fetch_out_buf #(
        .INSTR_W (2*HALF_W),
        .ADDR_W  (ADDR_W)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .flush     (buf_flush),
        .consume   (out_ready),
        .in_instr  ({mem_rdata, lo_q}),
        .in_pc     (pc),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc)
    );

    assign dbg_state = state;

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;
    import instr_fetch_seq_pkg::*;

    localparam int AW = 5;
    localparam int HW = 16;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   mem_addr;
    logic [HW-1:0]   mem_rdata;
    logic            mem_we;
    logic [HW-1:0]   mem_wdata;
    logic            prog_mode;
    logic            load_valid;
    logic            load_ready;
    logic [AW-1:0]   load_addr;
    logic [HW-1:0]   load_data;
    logic            redir_valid;
    logic [AW-1:0]   redir_pc;
    logic            out_valid;
    logic            out_ready;
    logic [2*HW-1:0] out_instr;
    logic [AW-1:0]   out_pc;
    logic            fetch_err;
    logic [1:0]      dbg_state;

    int tests = 0;
    int fails = 0;

    // expected {instr, pc}
    logic [2*HW+AW-1:0] exp_q[$];

    logic [HW-1:0] mem [32];

    instr_fetch_seq #(.ADDR_W(AW), .HALF_W(HW), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .prog_mode   (prog_mode),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .fetch_err   (fetch_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2*HW-1:0] instr, input logic [AW-1:0] pc);
        exp_q.push_back({instr, pc});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid, then holds out_ready for one edge.
    task automatic consume_one();
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL consume_timeout: got out_valid=0 expected 1 within 20 cycles");
        end else begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic redirect(input logic [AW-1:0] target);
        redir_valid = 1'b1;
        redir_pc    = target;
        tick();
        redir_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got instr %h pc %0d expected no beat", out_instr, out_pc);
            end else begin
                logic [2*HW+AW-1:0] e;
                e = exp_q.pop_front();
                tests++;
                if ({out_instr, out_pc} !== e) begin
                    fails++;
                    $display("FAIL sb_beat: got instr %h pc %0d expected instr %h pc %0d",
                             out_instr, out_pc, e[2*HW+AW-1:AW], e[AW-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [HW-1:0]   ld_tbl [4];
    logic [2*HW-1:0] held_instr;

    initial begin
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'h4444;
        for (int i = 4; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
        ld_tbl[0] = 16'hCAFE;
        ld_tbl[1] = 16'hBEEF;
        ld_tbl[2] = 16'h1234;
        ld_tbl[3] = 16'h5678;

        rst_n       = 1'b0;
        prog_mode   = 1'b0;
        load_valid  = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        out_ready   = 1'b0;

        // reset values
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", 32'(out_pc), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(F_LO));

        // streaming with out_ready=1: 2-cycle spacing
        push_exp(32'h2222_1111, 5'd0);
        push_exp(32'h4444_3333, 5'd2);
        push_exp(32'hA005_A004, 5'd4);
        out_ready = 1'b1;
        rst_n     = 1'b1;
        tick();
        check("first_valid_edge1", 32'(out_valid), 32'd0);
        tick();
        check("first_valid_edge2", 32'(out_valid), 32'd1);
        check("first_pc", 32'(out_pc), 32'd0);
        tick();
        check("gap_valid", 32'(out_valid), 32'd0);
        tick();
        check("second_valid", 32'(out_valid), 32'd1);
        check("second_pc", 32'(out_pc), 32'd2);
        tick();
        out_ready = 1'b0;

        // stall: buffer holds pc 4, FSM waits in F_HI re-reading pc+1
        repeat (4) tick();
        check("stall_state", 32'(dbg_state), 32'(F_HI));
        check("stall_mem_addr", 32'(mem_addr), 32'd7);
        check("stall_out_pc", 32'(out_pc), 32'd4);
        check("stall_valid", 32'(out_valid), 32'd1);
        held_instr = out_instr;
        tick();
        check("stall_instr_stable", out_instr, held_instr);
        check("stall_state2", 32'(dbg_state), 32'(F_HI));
        consume_one();

        // redirect to 6 while a (pc 6) beat is buffered: flushed
        check("pre_redir_valid", 32'(out_valid), 32'd1);
        redirect(5'd6);
        check("redir_flush", 32'(out_valid), 32'd0);
        push_exp(32'hA007_A006, 5'd6);
        consume_one();

        // odd redirect: ignored, sticky error
        redirect(5'd5);
        check("odd_fetch_err", 32'(fetch_err), 32'd1);
        push_exp(32'hA009_A008, 5'd8);
        consume_one();
        tick();
        check("odd_err_sticky", 32'(fetch_err), 32'd1);

        // wrap at the top of the address space
        redirect(5'd30);
        push_exp(32'hA01F_A01E, 5'd30);
        push_exp(32'h2222_1111, 5'd0);
        consume_one();
        consume_one();

        // program-load mode
        prog_mode = 1'b1;
        tick();
        check("load_state", 32'(dbg_state), 32'(LOAD));
        check("load_ready", 32'(load_ready), 32'd1);
        check("load_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_addr  = 5'(i);
            load_data  = ld_tbl[i];
            #1;
            check("load_we", 32'(mem_we), 32'd1);
            check("load_addr", 32'(mem_addr), 32'(i));
            check("load_wdata", 32'(mem_wdata), 32'(ld_tbl[i]));
            tick();
        end
        load_valid = 1'b0;
        #1;
        check("load_idle_we", 32'(mem_we), 32'd0);
        redirect(5'd12);
        check("load_redir_ignored", 32'(dbg_state), 32'(LOAD));
        prog_mode = 1'b0;
        tick();
        check("unload_state", 32'(dbg_state), 32'(F_LO));
        check("unload_ready", 32'(load_ready), 32'd0);
        check("unload_wdata", 32'(mem_wdata), 32'd0);
        push_exp(32'hBEEF_CAFE, 5'd0);
        push_exp(32'h5678_1234, 5'd2);
        consume_one();
        consume_one();

        // asynchronous reset mid-F_HI with a valid beat held
        begin
            int n = 0;
            while (!(dbg_state == F_HI && out_valid) && n < 20) begin
                tick();
                n++;
            end
        end
        check("pre_rst_state", 32'(dbg_state), 32'(F_HI));
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_instr", out_instr, 32'd0);
        check("async_rst_pc", 32'(out_pc), 32'd0);
        check("async_rst_err", 32'(fetch_err), 32'd0);
        check("async_rst_state", 32'(dbg_state), 32'(F_LO));
        tick();
        rst_n = 1'b1;
        push_exp(32'hBEEF_CAFE, 5'd0);
        consume_one();
        repeat (2) tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
